// File: rtl/perceptron_unit.sv
// rtl/perceptron_unit.sv - trainable Q16.16 neuron with selectable activation
// Registered forward path, combinational delta, online weight/bias update.
module perceptron_unit #(
  parameter int INPUT_UNITS  = 2,
  parameter int OUTPUT_UNITS = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic signed [31:0] i_values [INPUT_UNITS],
  input  logic        [1:0]  i_activation,
  input  logic               i_training,
  input  logic signed [31:0] i_learning_rate,
  input  logic signed [31:0] i_next_layer_weights [OUTPUT_UNITS],
  input  logic signed [31:0] i_error_gradient_next_layer [OUTPUT_UNITS],
  output logic signed [31:0] o_prediction,
  output logic signed [31:0] o_error_gradient,
  output logic signed [31:0] o_current_weights [INPUT_UNITS]
);

  localparam logic signed [31:0] ONE    = 32'sh0001_0000;
  localparam logic signed [31:0] HALF   = 32'sh0000_8000;
  localparam logic signed [31:0] SAT_HI = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SAT_LO = 32'sh8000_0000;
  localparam logic signed [31:0] W_INIT = 32'sh0000_4000;

  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? SAT_LO : SAT_HI;
    return s[31:0];
  endfunction

  function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic signed [32:0] s;
    s = {a[31], a} - {b[31], b};
    if (s[32] != s[31]) return s[32] ? SAT_LO : SAT_HI;
    return s[31:0];
  endfunction

  function automatic logic signed [31:0] sat_mul(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic signed [63:0] a64, b64, p;
    a64 = {{32{a[31]}}, a};
    b64 = {{32{b[31]}}, b};
    p   = (a64 * b64) >>> 16;
    // Anything not representable as a sign-extended 32-bit value clamps.
    if (p[63:31] != {33{p[63]}}) return p[63] ? SAT_LO : SAT_HI;
    return p[31:0];
  endfunction

  function automatic logic signed [31:0] sigmoid(input logic signed [31:0] z);
    logic signed [31:0] mag, f;
    mag = z[31] ? ((z == SAT_LO) ? SAT_HI : -z) : z;
    if (mag >= 32'sh0005_0000)      f = ONE;
    else if (mag >= 32'sh0002_6000) f = (mag >>> 5) + 32'sh0000_D800;
    else if (mag >= ONE)            f = (mag >>> 3) + 32'sh0000_A000;
    else                            f = (mag >>> 2) + HALF;
    return z[31] ? (ONE - f) : f;
  endfunction

  function automatic logic signed [31:0] activate(input logic signed [31:0] z,
                                                  input logic [1:0] sel);
    case (sel)
      2'd1:    return (z > 0) ? z : 32'sh0;
      2'd2:    return sigmoid(z);
      default: return z;
    endcase
  endfunction

  function automatic logic signed [31:0] derivative(input logic signed [31:0] z,
                                                    input logic [1:0] sel);
    logic signed [31:0] s;
    s = sigmoid(z);
    case (sel)
      2'd1:    return (z > 0) ? ONE : 32'sh0;
      2'd2:    return sat_mul(s, ONE - s);
      default: return ONE;
    endcase
  endfunction

  logic signed [31:0] r_weights [INPUT_UNITS];
  logic signed [31:0] r_x [INPUT_UNITS];
  logic signed [31:0] r_bias;
  logic signed [31:0] r_z;
  logic signed [31:0] r_prediction;

  logic signed [31:0] w_z;
  logic signed [31:0] w_backsum;
  logic signed [31:0] w_error_gradient;
  logic signed [31:0] w_step;

  always_comb begin
    w_z = 32'sh0;
    for (int i = 0; i < INPUT_UNITS; i++)
      w_z = sat_add(w_z, sat_mul(r_weights[i], i_values[i]));
    w_z = sat_add(w_z, r_bias);

    w_backsum = 32'sh0;
    for (int j = 0; j < OUTPUT_UNITS; j++)
      w_backsum = sat_add(w_backsum,
                          sat_mul(i_next_layer_weights[j], i_error_gradient_next_layer[j]));
    // Delta follows the live activation select, not the one used on the last edge.
    w_error_gradient = sat_mul(derivative(r_z, i_activation), w_backsum);
    w_step           = sat_mul(i_learning_rate, w_error_gradient);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < INPUT_UNITS; i++) begin
        r_weights[i] <= W_INIT;
        r_x[i]       <= 32'sh0;
      end
      r_bias       <= 32'sh0;
      r_z          <= 32'sh0;
      r_prediction <= 32'sh0;
    end else begin
      r_z          <= w_z;
      r_prediction <= activate(w_z, i_activation);
      for (int i = 0; i < INPUT_UNITS; i++) begin
        r_x[i] <= i_values[i];
        if (i_training) r_weights[i] <= sat_sub(r_weights[i], sat_mul(w_step, r_x[i]));
      end
      if (i_training) r_bias <= sat_sub(r_bias, w_step);
    end
  end

  always_comb begin
    for (int i = 0; i < INPUT_UNITS; i++) o_current_weights[i] = r_weights[i];
  end

  assign o_prediction     = r_prediction;
  assign o_error_gradient = w_error_gradient;

endmodule

// File: tb/tb_perceptron_unit.sv
// tb/tb_perceptron_unit.sv - scoreboard bench for perceptron_unit
// Directed steps queue expected values; each is compared once the DUT settles.
module tb_perceptron_unit;

  localparam logic signed [31:0] ONE  = 32'sh0001_0000;
  localparam logic signed [31:0] HALF = 32'sh0000_8000;
  localparam int K_PRED = 0, K_W0 = 1, K_W1 = 2, K_EGRAD = 3, K_GTHALF = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] values [2];
  logic        [1:0]  activation;
  logic               training;
  logic signed [31:0] learning_rate;
  logic signed [31:0] next_w [1];
  logic signed [31:0] egrad_next [1];
  logic signed [31:0] prediction;
  logic signed [31:0] error_gradient;
  logic signed [31:0] weights [2];

  always #5 clk = ~clk;

  perceptron_unit #(.INPUT_UNITS(2), .OUTPUT_UNITS(1)) dut (
    .i_clk                       (clk),
    .i_rst                       (rst),
    .i_values                    (values),
    .i_activation                (activation),
    .i_training                  (training),
    .i_learning_rate             (learning_rate),
    .i_next_layer_weights        (next_w),
    .i_error_gradient_next_layer (egrad_next),
    .o_prediction                (prediction),
    .o_error_gradient            (error_gradient),
    .o_current_weights           (weights)
  );

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] observe(int kind);
    case (kind)
      K_PRED:   return prediction;
      K_W0:     return weights[0];
      K_W1:     return weights[1];
      K_EGRAD:  return error_gradient;
      K_GTHALF: return {31'b0, (prediction > HALF)};
      default:  return 'x;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = observe(e.kind);
      n_cmp++;
      assert (got === e.exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", e.tag, got, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vals(input logic signed [31:0] a, input logic signed [31:0] b);
    values[0] = a;
    values[1] = b;
  endtask

  real s, t, d;
  int  pat;

  initial begin
    rst = 1'b1; activation = 2'd0; training = 1'b0; learning_rate = 32'sh0;
    set_vals(32'sh0, 32'sh0); next_w[0] = 32'sh0; egrad_next[0] = 32'sh0;

    // Reset state
    step();
    expect_val("rst_pred", K_PRED, 32'h0000_0000);
    expect_val("rst_w0", K_W0, 32'h0000_4000);
    expect_val("rst_w1", K_W1, 32'h0000_4000);
    expect_val("rst_egrad", K_EGRAD, 32'h0000_0000);
    check_sb();
    rst = 1'b0;

    // Sigmoid at zero, then its derivative, then immediate activation switch
    activation = 2'd2;
    step();
    expect_val("sig_zero", K_PRED, 32'h0000_8000);
    check_sb();
    next_w[0] = ONE; egrad_next[0] = ONE;
    #1;
    expect_val("sig_deriv_egrad", K_EGRAD, 32'h0000_4000);
    check_sb();
    activation = 2'd0;
    #1;
    expect_val("egrad_act_switch", K_EGRAD, 32'h0001_0000);
    check_sb();
    next_w[0] = 32'sh0; egrad_next[0] = 32'sh0; activation = 2'd2;

    // Sigmoid segments and their edges (weights 0.25, bias 0)
    set_vals(32'sh0004_0000, 32'sh0); step();
    expect_val("sig_z1", K_PRED, 32'h0000_C000); check_sb();
    set_vals(32'shFFFC_0000, 32'sh0); step();
    expect_val("sig_zm1", K_PRED, 32'h0000_4000); check_sb();
    set_vals(32'sh0009_8000, 32'sh0); step();
    expect_val("sig_z2375", K_PRED, 32'h0000_EB00); check_sb();
    set_vals(32'sh0009_7FFC, 32'sh0); step();
    expect_val("sig_below2375", K_PRED, 32'h0000_EBFF); check_sb();
    set_vals(32'sh0014_0000, 32'sh0); step();
    expect_val("sig_z5", K_PRED, 32'h0001_0000); check_sb();
    set_vals(32'shFFEC_0000, 32'sh0); step();
    expect_val("sig_zm5", K_PRED, 32'h0000_0000); check_sb();

    // Linear and ReLU
    activation = 2'd0; set_vals(ONE, ONE); step();
    expect_val("lin_11", K_PRED, 32'h0000_8000); check_sb();
    activation = 2'd1; set_vals(32'shFFFC_0000, 32'sh0); step();
    expect_val("relu_neg", K_PRED, 32'h0000_0000); check_sb();
    set_vals(ONE, ONE); step();
    expect_val("relu_pos", K_PRED, 32'h0000_8000); check_sb();

    // One training step
    activation = 2'd0; learning_rate = ONE; set_vals(ONE, 32'sh0); step();
    expect_val("lin_10", K_PRED, 32'h0000_4000); check_sb();
    next_w[0] = ONE; egrad_next[0] = ONE;
    #1;
    expect_val("train_egrad", K_EGRAD, 32'h0001_0000); check_sb();
    training = 1'b1; step();
    expect_val("train_w0", K_W0, 32'hFFFF_4000);
    expect_val("train_w1", K_W1, 32'h0000_4000);
    expect_val("train_fwd_old_w", K_PRED, 32'h0000_4000);
    check_sb();
    training = 1'b0; set_vals(32'sh0, 32'sh0); step();
    expect_val("bias_via_pred", K_PRED, 32'hFFFF_0000);
    expect_val("hold_w0", K_W0, 32'hFFFF_4000);
    check_sb();

    // Reset overrides training
    training = 1'b1; rst = 1'b1; step();
    rst = 1'b0; training = 1'b0; egrad_next[0] = 32'sh0;
    #1;
    expect_val("midrst_w0", K_W0, 32'h0000_4000);
    expect_val("midrst_w1", K_W1, 32'h0000_4000);
    expect_val("midrst_pred", K_PRED, 32'h0000_0000);
    expect_val("midrst_egrad", K_EGRAD, 32'h0000_0000);
    check_sb();

    // Saturation: grow weights to 8.25 then feed extreme inputs
    set_vals(ONE, ONE); step();
    egrad_next[0] = 32'shFFF8_0000;
    #1;
    expect_val("sat_egrad", K_EGRAD, 32'hFFF8_0000); check_sb();
    training = 1'b1; step();
    expect_val("sat_w0", K_W0, 32'h0008_4000);
    expect_val("sat_w1", K_W1, 32'h0008_4000);
    check_sb();
    training = 1'b0; egrad_next[0] = 32'sh0;
    set_vals(32'sh7FFF_0000, 32'sh7FFF_0000); step();
    expect_val("sat_pos", K_PRED, 32'h7FFF_FFFF); check_sb();
    set_vals(32'sh8000_0000, 32'sh8000_0000); step();
    expect_val("sat_neg_plus_bias", K_PRED, 32'h8008_0000); check_sb();

    // AND-gate learning with cross-entropy delta (pred - target)
    rst = 1'b1; step(); rst = 1'b0;
    activation = 2'd2; learning_rate = ONE; next_w[0] = ONE;
    for (int k = 0; k < 40; k++) begin
      pat = k % 4;
      set_vals(((pat & 2) != 0) ? ONE : 32'sh0, ((pat & 1) != 0) ? ONE : 32'sh0);
      training = 1'b0; egrad_next[0] = 32'sh0;
      step();
      s = $itor(prediction) / 65536.0;
      t = (pat == 3) ? 1.0 : 0.0;
      d = s * (1.0 - s);
      if (d < 1.0 / 65536.0) d = 1.0 / 65536.0;
      egrad_next[0] = $rtoi((s - t) / d * 65536.0);
      training = 1'b1;
      step();
    end
    training = 1'b0; egrad_next[0] = 32'sh0;
    for (int p = 0; p < 4; p++) begin
      set_vals(((p & 2) != 0) ? ONE : 32'sh0, ((p & 1) != 0) ? ONE : 32'sh0);
      step();
      expect_val($sformatf("and_p%0d", p), K_GTHALF, (p == 3) ? 32'h1 : 32'h0);
      check_sb();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
